// File: rtl/mac_pkg.sv
// mac_pkg: shared state type and default widths for the MAC accumulator bank
package mac_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} acc_state_t;
  localparam int IN_W_D = 16;
  localparam int ACC_W_D = 20;
  localparam int NCH_D = 4;
  localparam bit SAT_D = 1'b1;
endpackage

// File: rtl/acc_lane.sv
// acc_lane: one accumulator with sticky overflow and add/saturate/wrap logic
module acc_lane
  import mac_pkg::*;
#(
  parameter int IN_W = IN_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter bit SAT = SAT_D
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_upd,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic [IN_W-1:0]  i_data,
  output logic [ACC_W-1:0] o_value,
  output logic             o_ovf,
  output logic [ACC_W-1:0] o_nxt_value,
  output logic             o_nxt_ovf
);
  logic [ACC_W-1:0] r_value;
  logic             r_ovf;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]   w_sum;
  assign w_ext = ACC_W'(i_data);
  assign w_sum = {1'b0, r_value} + {1'b0, w_ext};
  assign o_value = r_value;
  assign o_ovf = r_ovf;
  always_comb begin
    o_nxt_value = i_clr ? '0 : !i_upd ? r_value : i_load ? w_ext :
                  (w_sum[ACC_W] && SAT) ? '1 : w_sum[ACC_W-1:0];
    o_nxt_ovf = i_clr ? 1'b0 : !i_upd ? r_ovf : i_load ? 1'b0 : (r_ovf | w_sum[ACC_W]);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_value <= o_nxt_value;
      r_ovf <= o_nxt_ovf;
    end
  end
endmodule

// File: rtl/mac_acc_bank.sv
// mac_acc_bank: multi-channel product accumulator with input stage, clear sweep and bypassed read port
module mac_acc_bank
  import mac_pkg::*;
#(
  parameter int IN_W = IN_W_D,
  parameter int ACC_W = ACC_W_D,
  parameter int NCH = NCH_D,
  parameter bit SAT = SAT_D,
  localparam int CH_W = $clog2(NCH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IN_W-1:0]  i_in_data,
  input  logic [CH_W-1:0]  i_in_ch,
  input  logic             i_in_load,
  input  logic             i_clr_all,
  input  logic             i_rd_en,
  input  logic [CH_W-1:0]  i_rd_ch,
  output logic             o_rd_valid,
  output logic [ACC_W-1:0] o_rd_data,
  output logic             o_rd_ovf,
  output logic             o_busy
);
  acc_state_t       r_state, w_next;
  logic [CH_W-1:0]  r_cnt;
  logic             r_s1_vld, r_s1_load;
  logic [IN_W-1:0]  r_s1_data;
  logic [CH_W-1:0]  r_s1_ch;
  logic [ACC_W-1:0] w_val [NCH];
  logic [ACC_W-1:0] w_nxt [NCH];
  logic [NCH-1:0]   w_ovf, w_nxt_ovf, w_upd, w_clr, w_wr;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (i_clr_all ? DRAIN : IDLE) :
             (r_state == DRAIN) ? CLEAR :
             (r_cnt == CH_W'(NCH - 1)) ? IDLE : CLEAR;
  end
  always_comb begin
    o_in_ready = r_state == IDLE;
    o_busy = r_state == CLEAR;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state != CLEAR) r_cnt <= '0;
    else r_cnt <= r_cnt + 1'b1;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_vld <= 1'b0;
      r_s1_load <= 1'b0;
      r_s1_data <= '0;
      r_s1_ch <= '0;
    end else begin
      r_s1_vld <= i_in_valid && o_in_ready;
      if (i_in_valid && o_in_ready) begin
        r_s1_load <= i_in_load;
        r_s1_data <= i_in_data;
        r_s1_ch <= i_in_ch;
      end
    end
  end
  for (genvar g = 0; g < NCH; g++) begin : g_lane
    assign w_upd[g] = r_s1_vld && r_s1_ch == CH_W'(g);
    assign w_clr[g] = r_state == CLEAR && r_cnt == CH_W'(g);
    assign w_wr[g] = w_upd[g] | w_clr[g];
    acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W), .SAT(SAT)) u_lane (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_upd(w_upd[g]),
      .i_load(r_s1_load),
      .i_clr(w_clr[g]),
      .i_data(r_s1_data),
      .o_value(w_val[g]),
      .o_ovf(w_ovf[g]),
      .o_nxt_value(w_nxt[g]),
      .o_nxt_ovf(w_nxt_ovf[g])
    );
  end
  // A lane being written this cycle returns its post-write value to the reader
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_valid <= 1'b0;
      o_rd_data <= '0;
      o_rd_ovf <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= w_wr[i_rd_ch] ? w_nxt[i_rd_ch] : w_val[i_rd_ch];
        o_rd_ovf <= w_wr[i_rd_ch] ? w_nxt_ovf[i_rd_ch] : w_ovf[i_rd_ch];
      end
    end
  end
endmodule
